// File: rtl/add_acc32_if.sv
// rtl/add_acc32_if.sv - operand/result handshake bundle for the streaming accumulator
interface add_acc32_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_sum;
    logic             out_carry;
    logic [CNT_W-1:0] out_count;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_carry, out_count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_carry, out_count
    );
endinterface

// File: rtl/add_acc32.sv
// rtl/add_acc32.sv - packet accumulator over a 32-bit ripple-carry adder; ACC_SAT_EN selects saturating total
module add_acc32_rca32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ci,
    output logic [31:0] s,
    output logic        co
);
    logic c;

    always_comb begin
        c = ci;
        s = '0;
        for (int i = 0; i < 32; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end
endmodule

module add_acc32 #(
    parameter int CNT_W = 8
) (
    input  logic        clock,
    input  logic        reset,
    add_acc32_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [31:0]      acc;
    logic             cflag;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      s;
    logic             co;
    logic [31:0]      acc_next;
    logic             accept;

    add_acc32_rca32 u_adder (
        .a  (acc),
        .b  (bus.in_data),
        .ci (1'b0),
        .s  (s),
        .co (co)
    );

    assign bus.in_ready  = (state_q != DONE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_sum   = acc;
    assign bus.out_carry = cflag;
    assign bus.out_count = cnt;
    assign accept        = bus.in_valid && bus.in_ready;

`ifdef ACC_SAT_EN
    // Any carry-out pins the total at all-ones; further nonzero beats carry again
    assign acc_next = co ? 32'hFFFF_FFFF : s;
`else
    assign acc_next = s;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = bus.in_last ? DONE : ACC;
                end
            end
            ACC: begin
                if (accept && bus.in_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            acc     <= '0;
            cflag   <= 1'b0;
            cnt     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                acc   <= acc_next;
                cflag <= cflag | co;
                if (cnt != {CNT_W{1'b1}}) begin
                    cnt <= cnt + 1'b1;
                end
            end else if (state_q == DONE && bus.out_ready) begin
                acc   <= '0;
                cflag <= 1'b0;
                cnt   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_add_acc32.sv
// tb/tb_add_acc32.sv - scoreboard bench for add_acc32 (default and CNT_W=2 instances)
module tb_add_acc32;
    typedef struct packed {
        logic [31:0] sum;
        logic        carry;
        logic [7:0]  count;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t qa[$];
    exp_t qb[$];

    always #5 clock = ~clock;

    add_acc32_if #(.CNT_W(8)) ifa ();
    add_acc32_if #(.CNT_W(2)) ifb ();

    add_acc32 #(.CNT_W(8)) dut_a (.clock(clock), .reset(reset), .bus(ifa.slave));
    add_acc32 #(.CNT_W(2)) dut_b (.clock(clock), .reset(reset), .bus(ifb.slave));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitors: pop one expected result per output handshake
    always @(negedge clock) begin
        exp_t e;
        if (!reset && ifa.out_valid && ifa.out_ready) begin
            if (qa.size() == 0) begin
                check("a_unexpected_result", 32'd1, 32'd0);
            end else begin
                e = qa.pop_front();
                check("a_sum", ifa.out_sum, e.sum);
                check("a_carry", {31'b0, ifa.out_carry}, {31'b0, e.carry});
                check("a_count", {24'b0, ifa.out_count}, {24'b0, e.count});
            end
        end
    end

    always @(negedge clock) begin
        exp_t e;
        if (!reset && ifb.out_valid && ifb.out_ready) begin
            if (qb.size() == 0) begin
                check("b_unexpected_result", 32'd1, 32'd0);
            end else begin
                e = qb.pop_front();
                check("b_sum", ifb.out_sum, e.sum);
                check("b_carry", {31'b0, ifb.out_carry}, {31'b0, e.carry});
                check("b_count", {30'b0, ifb.out_count}, {24'b0, e.count});
            end
        end
    end

    task automatic beat(input logic [31:0] data, input logic last, output int waits);
        waits = 0;
        ifa.in_valid = 1'b1;
        ifa.in_data  = data;
        ifa.in_last  = last;
        while (!ifa.in_ready && waits < 50) begin
            @(posedge clock);
            #1;
            waits++;
        end
        if (!ifa.in_ready) begin
            check("beat_ready_timeout", 32'd0, 32'd1);
        end
        @(posedge clock);
        #1;
        ifa.in_valid = 1'b0;
        ifa.in_data  = 32'hDEAD_BEEF;
        ifa.in_last  = 1'b0;
    endtask

    initial begin
        int w0, w1, w2;
        ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.in_last = 1'b0; ifa.out_ready = 1'b1;
        ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.in_last = 1'b0; ifb.out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("rst_in_ready", {31'b0, ifa.in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, ifa.out_valid}, 32'd0);
        check("rst_out_sum", ifa.out_sum, 32'd0);
        check("rst_out_carry", {31'b0, ifa.out_carry}, 32'd0);
        check("rst_out_count", {24'b0, ifa.out_count}, 32'd0);
        check("rst_b_in_ready", {31'b0, ifb.in_ready}, 32'd1);
        reset = 1'b0;

        // 1 + 2 + 3
        qa.push_back('{sum: 32'd6, carry: 1'b0, count: 8'd3});
        beat(32'd1, 1'b0, w0);
        check("latency_not_early", {31'b0, ifa.out_valid}, 32'd0);
        beat(32'd2, 1'b0, w0);
        beat(32'd3, 1'b1, w0);
        check("latency_out_valid", {31'b0, ifa.out_valid}, 32'd1);
        @(posedge clock); #1;

`ifdef ACC_SAT_EN
        qa.push_back('{sum: 32'hFFFF_FFFF, carry: 1'b1, count: 8'd2});
`else
        qa.push_back('{sum: 32'h0000_0001, carry: 1'b1, count: 8'd2});
`endif
        beat(32'hFFFF_FFFF, 1'b0, w0);
        beat(32'h0000_0002, 1'b1, w0);
        @(posedge clock); #1;

        // Hold the result for 5 cycles: 4 + 9
        ifa.out_ready = 1'b0;
        beat(32'd4, 1'b0, w0);
        beat(32'd9, 1'b1, w0);
        for (int i = 0; i < 5; i++) begin
            check("hold_in_ready", {31'b0, ifa.in_ready}, 32'd0);
            check("hold_out_valid", {31'b0, ifa.out_valid}, 32'd1);
            check("hold_sum", ifa.out_sum, 32'd13);
            check("hold_carry", {31'b0, ifa.out_carry}, 32'd0);
            check("hold_count", {24'b0, ifa.out_count}, 32'd2);
            @(posedge clock); #1;
        end
        qa.push_back('{sum: 32'd13, carry: 1'b0, count: 8'd2});
        ifa.out_ready = 1'b1;
        @(posedge clock); #1;
        check("release_out_valid", {31'b0, ifa.out_valid}, 32'd0);
        check("release_count", {24'b0, ifa.out_count}, 32'd0);
        check("release_in_ready", {31'b0, ifa.in_ready}, 32'd1);

        // Back-to-back packets {5} and {7,8}
        qa.push_back('{sum: 32'd5, carry: 1'b0, count: 8'd1});
        qa.push_back('{sum: 32'd15, carry: 1'b0, count: 8'd2});
        beat(32'd5, 1'b1, w0);
        beat(32'd7, 1'b0, w1);
        beat(32'd8, 1'b1, w2);
        check("b2b_first_wait", w0, 32'd0);
        check("b2b_bubble", w1, 32'd1);
        check("b2b_second_wait", w2, 32'd0);
        @(posedge clock); #1;

        // Abort mid-packet with reset
        beat(32'd100, 1'b0, w0);
        beat(32'd200, 1'b0, w0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("abort_in_ready", {31'b0, ifa.in_ready}, 32'd1);
        check("abort_out_valid", {31'b0, ifa.out_valid}, 32'd0);
        check("abort_sum", ifa.out_sum, 32'd0);
        check("abort_count", {24'b0, ifa.out_count}, 32'd0);
        qa.push_back('{sum: 32'd10, carry: 1'b0, count: 8'd1});
        beat(32'd10, 1'b1, w0);
        @(posedge clock); #1;

        // Narrow counter saturates at 3
        qb.push_back('{sum: 32'd5, carry: 1'b0, count: 8'd3});
        for (int i = 0; i < 5; i++) begin
            ifb.in_valid = 1'b1;
            ifb.in_data  = 32'd1;
            ifb.in_last  = (i == 4);
            check("sat_in_ready", {31'b0, ifb.in_ready}, 32'd1);
            @(posedge clock); #1;
        end
        ifb.in_valid = 1'b0;
        ifb.in_last  = 1'b0;
        check("sat_out_valid", {31'b0, ifb.out_valid}, 32'd1);

        for (int i = 0; i < 20 && (qa.size() != 0 || qb.size() != 0); i++) begin
            @(posedge clock); #1;
        end
        check("drain_qa", qa.size(), 32'd0);
        check("drain_qb", qb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
